// File: rtl/swap_div.sv
// swap_div: iterative restoring unsigned divider, one quotient bit per cycle.
// Takes the ordered pair from the swap/compare stage (i_A dividend, i_B divisor)
// and returns quotient/remainder with the upstream swap flag carried as a tag.
// Valid/ready handshake on both sides; results hold under backpressure.
module swap_div #(
   parameter int p_DATA_WIDTH = 32
) (
   input  logic                    i_CLK,
   input  logic                    i_RST,
   input  logic                    i_VALID,
   output logic                    o_READY,
   input  logic [p_DATA_WIDTH-1:0] i_A,
   input  logic [p_DATA_WIDTH-1:0] i_B,
   input  logic                    i_SWAPPED,
   output logic                    o_VALID,
   input  logic                    i_READY,
   output logic [p_DATA_WIDTH-1:0] o_Q,
   output logic [p_DATA_WIDTH-1:0] o_R,
   output logic                    o_DIV0,
   output logic                    o_SWAPPED
);

   localparam int N  = p_DATA_WIDTH;
   localparam int CW = $clog2(N);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);

   logic [1:0]    state_reg;
   logic [CW-1:0] cnt_reg;
   logic [N-1:0]  rem_reg;     // partial remainder; always < divisor so N bits hold it
   logic [N-1:0]  quo_reg;     // dividend shifting out, quotient bits shifting in
   logic [N-1:0]  div_reg;
   logic          tag_reg;
   logic [N-1:0]  q_out_reg;
   logic [N-1:0]  r_out_reg;
   logic          div0_out_reg;
   logic          tag_out_reg;

   logic [N:0]    shift_rem;   // N+1 bits so the compare cannot overflow
   logic          q_bit;
   logic [N-1:0]  rem_next;
   logic [N-1:0]  quo_next;

   // One restoring step: shift {R,Q} left, trial-subtract the divisor.
   always_comb begin
      shift_rem = {rem_reg, quo_reg[N-1]};
      q_bit     = (shift_rem >= {1'b0, div_reg});
      // When the subtraction is taken the result is < divisor, so the low N bits are exact.
      rem_next  = q_bit ? (shift_rem[N-1:0] - div_reg) : shift_rem[N-1:0];
      quo_next  = {quo_reg[N-2:0], q_bit};
   end

   assign o_READY   = (state_reg == ST_IDLE);
   assign o_VALID   = (state_reg == ST_DONE);
   assign o_Q       = q_out_reg;
   assign o_R       = r_out_reg;
   assign o_DIV0    = div0_out_reg;
   assign o_SWAPPED = tag_out_reg;

   // Control FSM plus datapath registers; reset abandons any division in flight.
   always_ff @(posedge i_CLK or posedge i_RST) begin
      if (i_RST) begin
         state_reg    <= ST_IDLE;
         cnt_reg      <= '0;
         rem_reg      <= '0;
         quo_reg      <= '0;
         div_reg      <= '0;
         tag_reg      <= 1'b0;
         q_out_reg    <= '0;
         r_out_reg    <= '0;
         div0_out_reg <= 1'b0;
         tag_out_reg  <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (i_VALID) begin
                  quo_reg   <= i_A;
                  div_reg   <= i_B;
                  tag_reg   <= i_SWAPPED;
                  rem_reg   <= '0;
                  cnt_reg   <= '0;
                  state_reg <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (div_reg == '0) begin
                  // Zero divisor: a single cycle here gives the one-cycle result latency.
                  // quo_reg still holds the untouched dividend.
                  q_out_reg    <= '1;
                  r_out_reg    <= quo_reg;
                  div0_out_reg <= 1'b1;
                  tag_out_reg  <= tag_reg;
                  state_reg    <= ST_DONE;
               end else begin
                  rem_reg <= rem_next;
                  quo_reg <= quo_next;
                  cnt_reg <= cnt_reg + CW'(1);
                  if (cnt_reg == LAST_STEP) begin
                     q_out_reg    <= quo_next;
                     r_out_reg    <= rem_next;
                     div0_out_reg <= 1'b0;
                     tag_out_reg  <= tag_reg;
                     state_reg    <= ST_DONE;
                  end
               end
            end
            ST_DONE: begin
               if (i_READY) begin
                  state_reg <= ST_IDLE;
               end
            end
            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_swap_div.sv
// tb_swap_div: randomized self-checking bench for swap_div, reference results
// computed with plain / and % arithmetic.
module tb_swap_div;

   localparam int N = 32;

   logic         i_CLK = 1'b0;
   logic         i_RST;
   logic         i_VALID;
   logic         o_READY;
   logic [N-1:0] i_A;
   logic [N-1:0] i_B;
   logic         i_SWAPPED;
   logic         o_VALID;
   logic         i_READY;
   logic [N-1:0] o_Q;
   logic [N-1:0] o_R;
   logic         o_DIV0;
   logic         o_SWAPPED;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 i_CLK = ~i_CLK;

   swap_div #(.p_DATA_WIDTH(N)) dut (
      .i_CLK     (i_CLK),
      .i_RST     (i_RST),
      .i_VALID   (i_VALID),
      .o_READY   (o_READY),
      .i_A       (i_A),
      .i_B       (i_B),
      .i_SWAPPED (i_SWAPPED),
      .o_VALID   (o_VALID),
      .i_READY   (i_READY),
      .o_Q       (o_Q),
      .o_R       (o_R),
      .o_DIV0    (o_DIV0),
      .o_SWAPPED (o_SWAPPED)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge i_CLK);
      #1;
   endtask

   task automatic scramble_inputs();
      i_A       = $urandom;
      i_B       = $urandom;
      i_SWAPPED = 1'($urandom_range(0, 1));
   endtask

   // One full transaction: accept, wait for result, backpressure, handoff.
   task automatic run_div(input logic [N-1:0] a, input logic [N-1:0] b, input logic sw,
                          input int hold, input bit garble);
      logic [N-1:0] eq;
      logic [N-1:0] er;
      logic         ediv0;
      int           exp_lat;
      int           lat;
      int           waitc;
      if (b == '0) begin
         eq = '1; er = a; ediv0 = 1'b1; exp_lat = 1;
      end else begin
         eq = a / b; er = a % b; ediv0 = 1'b0; exp_lat = N;
      end
      waitc = 0;
      while (!o_READY && waitc < 100) begin
         step();
         waitc++;
      end
      check("ready_before_accept", o_READY, 1);
      i_A = a; i_B = b; i_SWAPPED = sw; i_VALID = 1'b1; i_READY = 1'b0;
      step();
      check("ready_low_after_accept", o_READY, 0);
      i_VALID = garble;
      lat = 0;
      while (!o_VALID && lat < 200) begin
         scramble_inputs();
         step();
         lat++;
      end
      i_VALID = 1'b0;
      check("latency", lat, exp_lat);
      check("q", o_Q, eq);
      check("r", o_R, er);
      check("div0", o_DIV0, ediv0);
      check("swapped", o_SWAPPED, sw);
      for (int h = 0; h < hold; h++) begin
         step();
         check("hold_valid", o_VALID, 1);
         check("hold_ready", o_READY, 0);
         check("hold_q", o_Q, eq);
         check("hold_r", o_R, er);
         check("hold_div0", o_DIV0, ediv0);
         check("hold_swapped", o_SWAPPED, sw);
      end
      i_READY = 1'b1;
      step();
      i_READY = 1'b0;
      check("valid_drop_after_handoff", o_VALID, 0);
      check("ready_back_after_handoff", o_READY, 1);
      step();
      check("single_handoff", o_VALID, 0);
      $display("txn a=0x%08h b=0x%08h sw=%0d hold=%0d garble=%0d -> q=0x%08h r=0x%08h div0=%0d lat=%0d",
               a, b, sw, hold, garble, o_Q, o_R, o_DIV0, lat);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [N-1:0] ra;
      logic [N-1:0] rb;
      int           stale;

      i_RST = 1'b1; i_VALID = 1'b0; i_READY = 1'b0;
      i_A = '0; i_B = '0; i_SWAPPED = 1'b0;
      #12;
      check("reset_ready", o_READY, 1);
      check("reset_valid", o_VALID, 0);
      check("reset_q", o_Q, 0);
      check("reset_r", o_R, 0);
      check("reset_div0", o_DIV0, 0);
      check("reset_swapped", o_SWAPPED, 0);
      i_RST = 1'b0;
      step();

      // Directed cases
      run_div(32'd100, 32'd7, 1'b1, 0, 1'b0);
      run_div(32'd5, 32'd9, 1'b0, 0, 1'b0);
      run_div(32'hFFFF_FFFF, 32'd1, 1'b1, 0, 1'b0);
      run_div(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, 1'b0);
      run_div(32'd1234, 32'd0, 1'b1, 0, 1'b0);
      run_div(32'd1000, 32'd10, 1'b0, 5, 1'b0);

      // Reset in the middle of a division
      i_A = 32'd50; i_B = 32'd3; i_SWAPPED = 1'b1; i_VALID = 1'b1;
      step();
      i_VALID = 1'b0;
      for (int s = 0; s < 9; s++) step();
      #3;
      i_RST = 1'b1;
      #1;
      check("midrst_ready", o_READY, 1);
      check("midrst_valid", o_VALID, 0);
      check("midrst_q", o_Q, 0);
      check("midrst_r", o_R, 0);
      check("midrst_div0", o_DIV0, 0);
      check("midrst_swapped", o_SWAPPED, 0);
      #2;
      i_RST = 1'b0;
      stale = 0;
      for (int s = 0; s < 40; s++) begin
         step();
         if (o_VALID) stale++;
      end
      check("no_stale_result", stale, 0);
      run_div(32'd9, 32'd4, 1'b0, 0, 1'b0);

      // Continuous valid with changing operands during RUN
      run_div(32'd77777, 32'd13, 1'b1, 1, 1'b1);
      run_div(32'd4096, 32'd64, 1'b0, 0, 1'b1);

      // Randomized transactions
      for (int t = 0; t < 40; t++) begin
         ra = $urandom;
         case ($urandom_range(0, 7))
            0:       rb = '0;
            1, 2:    rb = N'($urandom_range(1, 255));
            3:       rb = ra >> $urandom_range(0, 31);
            default: rb = $urandom;
         endcase
         run_div(ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                 1'($urandom_range(0, 1)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
